buffer_read_controller: RTL and testbench

//  Read-side controller for the circular line buffer; the write controller fills the same buffer.

---
 rtl/buffer_read_controller.sv | 142 ++++++++++++++
 tb/tb_buffer_read_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_read_controller.sv
// Read-side controller for the circular line buffer: waits for a full window, streams it, frees STRIDE.
// Optional window counter (port win_cnt) is built when BUF_RD_WINCNT_EN is defined.
module buffer_read_controller #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int CW     = 5,
  parameter int WIN    = 4,
  parameter int STRIDE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] count,
  output logic          ren,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          rel,
  output logic          stall,
  output logic          busy
`ifdef BUF_RD_WINCNT_EN
  ,
  output logic [15:0]   win_cnt
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STRIDE_X = (AW+1)'(STRIDE);
  localparam logic [AW-1:0] LAST_OFF = AW'(WIN-1);
  localparam logic [CW-1:0] WIN_C    = CW'(WIN);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] offset;
  logic [AW:0]   sum_a;
  logic [AW:0]   sum_aw;
  logic [AW:0]   sum_p;
  logic [AW:0]   sum_pw;
  logic [AW-1:0] ptr_n;
  logic          at_last;
  logic          enough;

  // Address and pointer sums are one bit wider so the wrap compare sees overflow.
  always_comb begin
    sum_a  = {1'b0, rd_ptr} + {1'b0, offset};
    sum_aw = sum_a - DEPTH_X;
    sum_p  = {1'b0, rd_ptr} + STRIDE_X;
    sum_pw = sum_p - DEPTH_X;
    raddr  = (sum_a >= DEPTH_X) ? sum_aw[AW-1:0] : sum_a[AW-1:0];
    ptr_n  = (sum_p >= DEPTH_X) ? sum_pw[AW-1:0] : sum_p[AW-1:0];
  end

  assign at_last = (offset == LAST_OFF);
  assign enough  = (count >= WIN_C);

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (en) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (enough)   state_n = S_FETCH;
        else if (!en) state_n = S_IDLE;
      end
      S_FETCH: begin
        state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_n = S_SEND;
      end
      S_SEND: begin
        if (out_ready)
          state_n = at_last ? S_RELEASE : S_FETCH;
      end
      S_RELEASE: begin
        state_n = en ? S_WAIT : S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Window offset: advances on each accepted word, cleared at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset <= '0;
    end else if (state == S_SEND && out_ready && !at_last) begin
      offset <= offset + 1'b1;
    end else if (state == S_RELEASE) begin
      offset <= '0;
    end
  end

  // Read pointer advances by STRIDE modulo DEPTH per completed window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    rd_ptr <= '0;
    else if (state == S_RELEASE) rd_ptr <= ptr_n;
  end

  // Output word captured one cycle after the read; held through SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    out_data <= '0;
    else if (state == S_CAPTURE) out_data <= rdata;
  end

`ifdef BUF_RD_WINCNT_EN
  // Released-window counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    win_cnt <= '0;
    else if (state == S_RELEASE) win_cnt <= win_cnt + 16'd1;
  end
`endif

  assign ren       = (state == S_FETCH);
  assign out_valid = (state == S_SEND);
  assign out_last  = out_valid && at_last;
  assign rel       = (state == S_RELEASE);
  assign stall     = (state == S_WAIT) && !enough;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_buffer_read_controller.sv
// Directed bench for buffer_read_controller (DEPTH=8, WIN=4, STRIDE=2).
// Buffer model returns rdata = address one cycle after ren.
module tb_buffer_read_controller;
  localparam int DW = 8, DEPTH = 8, AW = 3, CW = 4;
  localparam int WIN = 4, STRIDE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] count;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          rel;
  logic          stall;
  logic          busy;
`ifdef BUF_RD_WINCNT_EN
  logic [15:0]   win_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int nwin = 0;
  int a;

  always #5 clk = ~clk;

  always @(posedge clk) if (ren) rdata <= DW'(raddr);

  buffer_read_controller #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW),
    .WIN(WIN), .STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .rel(rel), .stall(stall), .busy(busy)
`ifdef BUF_RD_WINCNT_EN
    , .win_cnt(win_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int addr);
    bit ok = 0;
    addr = -1;
    for (int i = 0; i < 20; i++) begin
      if (ren === 1'b1) addr = int'(raddr);
      if (out_valid === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL valid_timeout obs=0 exp=1");
    end
  endtask

  task automatic get_word(input int exp, input logic last);
    int ad;
    wait_valid(ad);
    chk("raddr", ad, exp);
    chk("data", out_data, exp);
    chk("last", out_last, last);
    @(negedge clk);
  endtask

  task automatic finish_win();
    chk("rel_on", rel, 1'b1);
    nwin++;
    @(negedge clk);
    chk("rel_off", rel, 1'b0);
`ifdef BUF_RD_WINCNT_EN
    chk("win_cnt", win_cnt, nwin);
`endif
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; count = '0; out_ready = 1'b0;
    #1;
    chk("rst_ren", ren, 1'b0);
    chk("rst_raddr", raddr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_rel", rel, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", busy, 1'b0);

    @(negedge clk);
    rst = 1'b1; en = 1'b1; count = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("starve_stall", stall, 1'b1);
      chk("starve_ren", ren, 1'b0);
    end
    chk("wait_busy", busy, 1'b1);

    count = 4'd4;
    @(negedge clk);
    chk("go_ren", ren, 1'b1);
    chk("go_raddr", raddr, 0);
    chk("go_stall", stall, 1'b0);

    out_ready = 1'b1;
    get_word(0, 0); get_word(1, 0);
    get_word(2, 0); get_word(3, 1);
    finish_win();

    get_word(2, 0); get_word(3, 0);
    get_word(4, 0); get_word(5, 1);
    finish_win();

    get_word(4, 0); get_word(5, 0);
    get_word(6, 0); get_word(7, 1);
    finish_win();

    get_word(6, 0); get_word(7, 0);
    get_word(0, 0); get_word(1, 1);
    finish_win();

    get_word(0, 0);
    out_ready = 1'b0;
    wait_valid(a);
    chk("bp_raddr", a, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 1);
      chk("bp_last", out_last, 1'b0);
      chk("bp_ren", ren, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_hold", out_valid, 1'b1);
    @(negedge clk);
    chk("bp_acc_valid", out_valid, 1'b0);
    chk("bp_next_ren", ren, 1'b1);
    chk("bp_next_raddr", raddr, 2);
    get_word(2, 0); get_word(3, 1);
    finish_win();

    get_word(2, 0);
    en = 1'b0;
    get_word(3, 0); get_word(4, 0); get_word(5, 1);
    finish_win();
    chk("idle_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ren", ren, 1'b0);
      chk("idle_busy2", busy, 1'b0);
    end

    en = 1'b1;
    wait_valid(a);
    chk("pre_rst_raddr", a, 4);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ren", ren, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_data", out_data, 0);
`ifdef BUF_RD_WINCNT_EN
    chk("arst_win_cnt", win_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    get_word(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
